// File: rtl/defect_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : defect_pkg                                                   |
// | Description : Shared constants for the defect overlay: coordinate width,   |
// |               image size defaults, RGB565 colours, FSM state encoding and  |
// |               the cross-marker proximity helper.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package defect_pkg;

   localparam int COORD_WID = 11;

   localparam logic [COORD_WID-1:0] IMG_WIDTH_DEF  = 11'd640;
   localparam logic [COORD_WID-1:0] IMG_HEIGHT_DEF = 11'd480;

   localparam logic [15:0] RGB565_RED   = 16'hF800;
   localparam logic [15:0] RGB565_CYAN  = 16'h07FF;
   localparam logic [15:0] RGB565_BLACK = 16'h0000;

   // Half-length of each marker arm; one bit wider than a coordinate.
   localparam logic [COORD_WID:0] MARK_ARM = 12'd3;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_SHOW = 1'b1
   } ovl_state_t;

   // True when pos lies within MARK_ARM of centre c; the widened compare
   // keeps arms near coordinate 0 from wrapping to the far image edge.
   function automatic logic near_point(input logic [COORD_WID-1:0] pos,
                                       input logic [COORD_WID-1:0] c);
      logic [COORD_WID:0] p;
      logic [COORD_WID:0] cc;
      p  = {1'b0, pos};
      cc = {1'b0, c};
      return ((p + MARK_ARM) >= cc) && (p <= (cc + MARK_ARM));
   endfunction

endpackage
`default_nettype wire

// File: rtl/ovl_edge_cmp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : ovl_edge_cmp                                                 |
// | Description : For one axis, flags whether a position lies inside [lo..hi]  |
// |               and whether it lies within LINE_W of either edge.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module ovl_edge_cmp
   import defect_pkg::*;
#(
   parameter int LINE_W = 2
) (
   input  logic [COORD_WID-1:0] pos,
   input  logic [COORD_WID-1:0] lo,
   input  logic [COORD_WID-1:0] hi,
   output logic                 in_range,
   output logic                 near_edge
);

   localparam logic [COORD_WID:0] LW = (COORD_WID+1)'(LINE_W);

   logic [COORD_WID:0] pos_e;
   logic [COORD_WID:0] lo_e;
   logic [COORD_WID:0] hi_e;

   assign pos_e = {1'b0, pos};
   assign lo_e  = {1'b0, lo};
   assign hi_e  = {1'b0, hi};

   assign in_range  = (pos_e >= lo_e) && (pos_e <= hi_e);
   // pos > hi-LW is rewritten as pos+LW > hi so a small hi never underflows.
   assign near_edge = (pos_e < (lo_e + LW)) || ((pos_e + LW) > hi_e);

endmodule
`default_nettype wire

// File: rtl/defect_overlay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : defect_overlay                                               |
// | Description : Draws a bounding rectangle from the four extreme defect      |
// |               points onto an RGB565 stream, 2-cycle aligned pipeline.      |
// |               Box coordinates latch at the vs rising edge only.            |
// |               OVERLAY_CROSS_EN adds plus markers on each defect point.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module defect_overlay
   import defect_pkg::*;
#(
   parameter logic [COORD_WID-1:0] IMG_WIDTH   = IMG_WIDTH_DEF,
   parameter logic [COORD_WID-1:0] IMG_HEIGHT  = IMG_HEIGHT_DEF,
   parameter int                   LINE_W      = 2,
   parameter int                   HOLD_FRAMES = 8,
   parameter logic [15:0]          BOX_COLOR   = RGB565_RED
) (
   input  logic                 pixclk_in,
   input  logic                 rst_out,
   input  logic                 vid_vs,
   input  logic                 vid_de,
   input  logic [15:0]          vid_data,
   input  logic [COORD_WID-1:0] defect_p1_x,
   input  logic [COORD_WID-1:0] defect_p1_y,
   input  logic [COORD_WID-1:0] defect_p2_x,
   input  logic [COORD_WID-1:0] defect_p2_y,
   input  logic [COORD_WID-1:0] defect_p3_x,
   input  logic [COORD_WID-1:0] defect_p3_y,
   input  logic [COORD_WID-1:0] defect_p4_x,
   input  logic [COORD_WID-1:0] defect_p4_y,
   input  logic                 defect_valid,
   output logic                 ovl_vs,
   output logic                 ovl_de,
   output logic [15:0]          ovl_data,
   output logic                 box_active
);

   localparam logic [COORD_WID-1:0] X_MAX     = IMG_WIDTH  - COORD_WID'(1);
   localparam logic [COORD_WID-1:0] Y_MAX     = IMG_HEIGHT - COORD_WID'(1);
   localparam logic [7:0]           HOLD_INIT = 8'(HOLD_FRAMES);

   logic [COORD_WID-1:0] x_cnt, y_cnt;
   logic [COORD_WID-1:0] xl, xr, yt, yb;
   logic [7:0]           hold_cnt;
   ovl_state_t           state;
   logic                 vs_d1, de_d1, box_d1, mark_d1;
   logic [15:0]          data_d1;
   logic                 vs_rise, de_fall, show;
   logic                 x_in, x_near, y_in, y_near;
   logic                 draw_box, draw_mark;

   assign vs_rise = vid_vs & ~vs_d1;
   assign de_fall = ~vid_de & de_d1;
   assign show    = (state == ST_SHOW);

   // Pixel position counters, saturating at the image size.
   always_ff @(posedge pixclk_in or posedge rst_out) begin
      if (rst_out) begin
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         if (vid_de) begin
            if (x_cnt < X_MAX) x_cnt <= x_cnt + COORD_WID'(1);
         end else if (de_fall) begin
            x_cnt <= '0;
         end
         if (vid_vs) begin
            y_cnt <= '0;
         end else if (de_fall && (y_cnt < Y_MAX)) begin
            y_cnt <= y_cnt + COORD_WID'(1);
         end
      end
   end

   // Once-per-frame latch of the box edges plus the SHOW/IDLE state machine.
   always_ff @(posedge pixclk_in or posedge rst_out) begin
      if (rst_out) begin
         xl         <= '0;
         xr         <= '0;
         yt         <= '0;
         yb         <= '0;
         hold_cnt   <= '0;
         state      <= ST_IDLE;
         box_active <= 1'b0;
      end else if (vs_rise) begin
         if (defect_valid) begin
            xl         <= defect_p1_x;
            xr         <= defect_p2_x;
            yt         <= defect_p3_y;
            yb         <= defect_p4_y;
            hold_cnt   <= HOLD_INIT;
            state      <= ST_SHOW;
            box_active <= 1'b1;
         end else begin
            if (hold_cnt != 8'd0) hold_cnt <= hold_cnt - 8'd1;
            // Staying in SHOW needs a non-zero count after this decrement.
            if (show && (hold_cnt > 8'd1)) begin
               state      <= ST_SHOW;
               box_active <= 1'b1;
            end else begin
               state      <= ST_IDLE;
               box_active <= 1'b0;
            end
         end
      end
   end

   ovl_edge_cmp #(.LINE_W(LINE_W)) u_x_cmp (
      .pos       (x_cnt),
      .lo        (xl),
      .hi        (xr),
      .in_range  (x_in),
      .near_edge (x_near)
   );

   ovl_edge_cmp #(.LINE_W(LINE_W)) u_y_cmp (
      .pos       (y_cnt),
      .lo        (yt),
      .hi        (yb),
      .in_range  (y_in),
      .near_edge (y_near)
   );

   assign draw_box = show & vid_de & x_in & y_in & (x_near | y_near);

`ifdef OVERLAY_CROSS_EN
   logic [COORD_WID-1:0] pt_x [4];
   logic [COORD_WID-1:0] pt_y [4];

   // Point shadows for the markers, updated on the same edge as the box.
   always_ff @(posedge pixclk_in or posedge rst_out) begin
      if (rst_out) begin
         for (int i = 0; i < 4; i++) begin
            pt_x[i] <= '0;
            pt_y[i] <= '0;
         end
      end else if (vs_rise && defect_valid) begin
         pt_x[0] <= defect_p1_x;  pt_y[0] <= defect_p1_y;
         pt_x[1] <= defect_p2_x;  pt_y[1] <= defect_p2_y;
         pt_x[2] <= defect_p3_x;  pt_y[2] <= defect_p3_y;
         pt_x[3] <= defect_p4_x;  pt_y[3] <= defect_p4_y;
      end
   end

   // Plus-shaped hit test around each point; clipping falls out of the counters.
   always_comb begin
      draw_mark = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (((x_cnt == pt_x[i]) && near_point(y_cnt, pt_y[i])) ||
             ((y_cnt == pt_y[i]) && near_point(x_cnt, pt_x[i])))
            draw_mark = 1'b1;
      end
      if (!(show && vid_de)) draw_mark = 1'b0;
   end
`else
   logic unused_coords;
   assign unused_coords = ^{defect_p1_y, defect_p2_y, defect_p3_x, defect_p4_x};
   assign draw_mark     = 1'b0;
`endif

   // Two-stage aligned video pipe; colour is selected in the second stage.
   always_ff @(posedge pixclk_in or posedge rst_out) begin
      if (rst_out) begin
         vs_d1    <= 1'b0;
         de_d1    <= 1'b0;
         data_d1  <= '0;
         box_d1   <= 1'b0;
         mark_d1  <= 1'b0;
         ovl_vs   <= 1'b0;
         ovl_de   <= 1'b0;
         ovl_data <= '0;
      end else begin
         vs_d1   <= vid_vs;
         de_d1   <= vid_de;
         data_d1 <= vid_data;
         box_d1  <= draw_box;
         mark_d1 <= draw_mark;
         ovl_vs  <= vs_d1;
         ovl_de  <= de_d1;
         if (!de_d1)       ovl_data <= RGB565_BLACK;
         else if (mark_d1) ovl_data <= ~BOX_COLOR;
         else if (box_d1)  ovl_data <= BOX_COLOR;
         else              ovl_data <= data_d1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_defect_overlay.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_defect_overlay                                            |
// | Description : Directed self-checking bench for defect_overlay.             |
// |               Cross-marker vectors run only with OVERLAY_CROSS_EN.         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_defect_overlay;

   logic        pixclk_in = 1'b0;
   logic        rst_out;
   logic        vid_vs, vid_de, defect_valid;
   logic [15:0] vid_data;
   logic [10:0] p1x, p1y, p2x, p2y, p3x, p3y, p4x, p4y;
   logic        ovl_vs, ovl_de, box_active;
   logic [15:0] ovl_data;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int    x;
      int    y;
      bit    box;
      logic [15:0] color;
      string tag;
   } chk_t;
   chk_t chk_q[$];

   bit          pend_chk [2];
   logic [15:0] pend_exp [2];
   string       pend_tag [2];

   int          chg_line = -1;
   logic [10:0] n1x, n2x, n3y, n4y;

   always #5 pixclk_in = ~pixclk_in;

   defect_overlay dut (
      .pixclk_in    (pixclk_in),
      .rst_out      (rst_out),
      .vid_vs       (vid_vs),
      .vid_de       (vid_de),
      .vid_data     (vid_data),
      .defect_p1_x  (p1x),
      .defect_p1_y  (p1y),
      .defect_p2_x  (p2x),
      .defect_p2_y  (p2y),
      .defect_p3_x  (p3x),
      .defect_p3_y  (p3y),
      .defect_p4_x  (p4x),
      .defect_p4_y  (p4y),
      .defect_valid (defect_valid),
      .ovl_vs       (ovl_vs),
      .ovl_de       (ovl_de),
      .ovl_data     (ovl_data),
      .box_active   (box_active)
   );

   task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   function automatic logic [15:0] pix_pat(input int x, input int y);
      return 16'h0800 | 16'(((y % 32) * 64) + (x % 64));
   endfunction

   // One pixel-clock slot: checks the slot driven two cycles earlier, then drives.
   task automatic drive(input logic vs, input logic de, input logic [15:0] d,
                        input bit chk, input logic [15:0] ex, input string tag);
      @(negedge pixclk_in);
      if (pend_chk[1]) check_value(pend_tag[1], {16'h0, ovl_data}, {16'h0, ex_hold(1)});
      pend_chk[1] = pend_chk[0];
      pend_exp[1] = pend_exp[0];
      pend_tag[1] = pend_tag[0];
      pend_chk[0] = chk;
      pend_exp[0] = ex;
      pend_tag[0] = tag;
      vid_vs   = vs;
      vid_de   = de;
      vid_data = d;
   endtask

   function automatic logic [15:0] ex_hold(input int i);
      return pend_exp[i];
   endfunction

   task automatic add_chk(input int x, input int y, input bit box,
                          input logic [15:0] color, input string tag);
      chk_t c;
      c.x = x; c.y = y; c.box = box; c.color = color; c.tag = tag;
      chk_q.push_back(c);
   endtask

   task automatic set_box(input int xl, input int xr, input int yt, input int yb);
      p1x = 11'(xl); p2x = 11'(xr); p3y = 11'(yt); p4y = 11'(yb);
   endtask

   // Vertical blank, then active lines; queued checks are matched by position.
   task automatic run_frame(input int lines, input int pix, input bit exp_act, input string ftag);
      for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
      check_value({ftag, "_active"}, {31'h0, box_active}, {31'h0, exp_act});
      for (int l = 0; l < lines; l++) begin
         if (l == chg_line) begin
            p1x = n1x; p2x = n2x; p3y = n3y; p4y = n4y;
         end
         for (int p = 0; p < pix; p++) begin
            bit          hit;
            logic [15:0] ex;
            string       tg;
            hit = 1'b0; ex = pix_pat(p, l); tg = "";
            foreach (chk_q[k]) begin
               if (chk_q[k].x == p && chk_q[k].y == l) begin
                  hit = 1'b1;
                  tg  = chk_q[k].tag;
                  if (chk_q[k].box) ex = chk_q[k].color;
               end
            end
            drive(1'b0, 1'b1, pix_pat(p, l), hit, ex, tg);
         end
         drive(1'b0, 1'b0, 16'hABCD, 1'b0, 16'h0, "");
         drive(1'b0, 1'b0, 16'hABCD, 1'b0, 16'h0, "");
      end
      chk_q.delete();
      chg_line = -1;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_out = 1'b1;
      vid_vs = 1'b0; vid_de = 1'b0; vid_data = 16'h0; defect_valid = 1'b0;
      p1x = '0; p1y = '0; p2x = '0; p2y = '0; p3x = '0; p3y = '0; p4x = '0; p4y = '0;
      n1x = '0; n2x = '0; n3y = '0; n4y = '0;
      for (int i = 0; i < 2; i++) begin pend_chk[i] = 1'b0; pend_exp[i] = '0; pend_tag[i] = ""; end

      // Reset state and mid-line reset.
      repeat (3) @(negedge pixclk_in);
      check_value("rst_vs",     {31'h0, ovl_vs},     32'h0);
      check_value("rst_de",     {31'h0, ovl_de},     32'h0);
      check_value("rst_data",   {16'h0, ovl_data},   32'h0);
      check_value("rst_active", {31'h0, box_active}, 32'h0);
      rst_out = 1'b0;
      for (int p = 0; p < 6; p++)
         drive(1'b0, 1'b1, pix_pat(p, 0), (p == 2), pix_pat(p, 0), "pre_rst_pass");
      rst_out = 1'b1;
      for (int p = 0; p < 5; p++)
         drive(1'b0, 1'b1, pix_pat(p + 6, 0), 1'b0, 16'h0, "");
      check_value("midrst_de",     {31'h0, ovl_de},     32'h0);
      check_value("midrst_data",   {16'h0, ovl_data},   32'h0);
      check_value("midrst_vs",     {31'h0, ovl_vs},     32'h0);
      check_value("midrst_active", {31'h0, box_active}, 32'h0);
      drive(1'b0, 1'b1, 16'h1234, 1'b1, 16'h1234, "post_rst_pass");
      rst_out = 1'b0;
      drive(1'b0, 1'b1, 16'h2345, 1'b0, 16'h0, "");
      check_value("lat1_de", {31'h0, ovl_de}, 32'h0);
      drive(1'b0, 1'b1, 16'h3456, 1'b0, 16'h0, "");
      check_value("lat2_de", {31'h0, ovl_de}, 32'h1);
      drive(1'b0, 1'b0, 16'hABCD, 1'b1, 16'h0000, "de_low_zero");
      drive(1'b0, 1'b0, 16'hABCD, 1'b0, 16'h0, "");

      // Main rectangle.
      set_box(100, 200, 50, 150); p1y = 11'd77; p2y = 11'd99;
      defect_valid = 1'b1;
      add_chk(100, 80,  1, 16'hF800, "box_left_edge");
      add_chk(102, 80,  0, 16'h0,    "box_inner_pass");
      add_chk(99,  80,  0, 16'h0,    "box_left_outside");
      add_chk(150, 50,  1, 16'hF800, "box_top_edge");
      add_chk(150, 150, 1, 16'hF800, "box_bottom_edge");
      add_chk(150, 151, 0, 16'h0,    "box_below_pass");
      add_chk(199, 100, 1, 16'hF800, "box_right_edge");
      add_chk(198, 100, 0, 16'h0,    "box_right_inner");
      run_frame(152, 202, 1'b1, "box");

      // Hold: valid for one frame, then drawn for HOLD_FRAMES frames in total.
      set_box(2, 5, 1, 3);
      for (int f = 1; f <= 9; f++) begin
         add_chk(2, 2, (f <= 8), 16'hF800, $sformatf("hold_px_f%0d", f));
         run_frame(5, 8, (f <= 8), $sformatf("hold_f%0d", f));
         defect_valid = 1'b0;
      end

      // Coordinates change mid-frame: box follows only at the next frame.
      defect_valid = 1'b1;
      set_box(2, 5, 1, 3);
      n1x = 11'd0; n2x = 11'd6; n3y = 11'd0; n4y = 11'd4;
      chg_line = 2;
      add_chk(2, 3, 1, 16'hF800, "midchg_old_box");
      add_chk(0, 3, 0, 16'h0,    "midchg_new_absent");
      run_frame(5, 8, 1'b1, "midchg_a");
      add_chk(0, 3, 1, 16'hF800, "midchg_new_box");
      add_chk(2, 2, 0, 16'h0,    "midchg_new_inner");
      run_frame(5, 8, 1'b1, "midchg_b");

      // Degenerate box.
      set_box(300, 200, 1, 3);
      add_chk(250, 2, 0, 16'h0, "degen_mid");
      add_chk(200, 1, 0, 16'h0, "degen_xr");
      add_chk(300, 1, 0, 16'h0, "degen_xl");
      run_frame(3, 302, 1'b1, "degen");

      // Single-pixel box at the origin.
      set_box(0, 0, 0, 0);
      add_chk(0, 0, 1, 16'hF800, "single_px");
      add_chk(1, 0, 0, 16'h0,    "single_right");
      add_chk(0, 1, 0, 16'h0,    "single_below");
      add_chk(1, 1, 0, 16'h0,    "single_diag");
      run_frame(3, 4, 1'b1, "single");

      // Over-long line: x saturates at the last column.
      set_box(639, 639, 0, 0);
      add_chk(638, 0, 0, 16'h0,    "sat_before");
      add_chk(639, 0, 1, 16'hF800, "sat_last_col");
      add_chk(643, 0, 1, 16'hF800, "sat_overrun");
      run_frame(1, 645, 1'b1, "sat");

`ifdef OVERLAY_CROSS_EN
      // Clipped marker at the origin.
      p1x = 11'd0;  p1y = 11'd0;
      p2x = 11'd10; p2y = 11'd8;
      p3x = 11'd5;  p3y = 11'd0;
      p4x = 11'd5;  p4y = 11'd8;
      add_chk(0,   0, 1, 16'h07FF, "mark_origin");
      add_chk(3,   0, 1, 16'h07FF, "mark_arm_x");
      add_chk(0,   3, 1, 16'h07FF, "mark_arm_y");
      add_chk(0,   4, 1, 16'hF800, "mark_box_below");
      add_chk(639, 0, 0, 16'h0,    "mark_no_wrap");
      run_frame(5, 640, 1'b1, "mark");
`endif

      defect_valid = 1'b0;
      drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
      drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");
      drive(1'b1, 1'b0, 16'h0, 1'b0, 16'h0, "");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
